// File: rtl/countdown_timer_if.sv
// Control, preset and display bundle for countdown_timer.
// The master drives load/enable/presets; the slave (the timer) drives digits and status.
interface countdown_timer_if;
    logic       load;
    logic       enable;
    logic [3:0] preset_sec_unit;
    logic [3:0] preset_sec_tens;
    logic [3:0] preset_min_unit;
    logic [3:0] preset_min_tens;
    logic [3:0] sec_unit;
    logic [3:0] sec_tens;
    logic [3:0] min_unit;
    logic [3:0] min_tens;
    logic [1:0] state;
    logic       running;
    logic       done;
    logic       alarm;

    modport master (
        output load, enable,
        output preset_sec_unit, preset_sec_tens, preset_min_unit, preset_min_tens,
        input  sec_unit, sec_tens, min_unit, min_tens,
        input  state, running, done, alarm
    );

    modport slave (
        input  load, enable,
        input  preset_sec_unit, preset_sec_tens, preset_min_unit, preset_min_tens,
        output sec_unit, sec_tens, min_unit, min_tens,
        output state, running, done, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with timed alarm on expiry.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and keep running.
module countdown_timer #(
    parameter int ALARM_CYCLES = 10
) (
    input  logic               clk_1hz,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam int ACW = (ALARM_CYCLES > 0) ? $clog2(ALARM_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Digit index: 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens.
    state_t           state_reg, state_next;
    logic [3:0]       digit_reg [4];
    logic [3:0]       digit_next [4];
    logic [3:0]       digit_dec [4];
    logic [3:0]       preset_in [4];
    logic [3:0]       preset_clean [4];
    logic [4:0]       borrow;
    logic             done_reg, done_next;
    logic             alarm_reg, alarm_next;
    logic [ACW-1:0]   alarm_cnt_reg, alarm_cnt_next;
    logic             count_zero;
    logic             count_one;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [3:0]       preset_reg [4];
    logic [3:0]       preset_next [4];
`endif

    assign preset_in[0] = bus.preset_sec_unit;
    assign preset_in[1] = bus.preset_sec_tens;
    assign preset_in[2] = bus.preset_min_unit;
    assign preset_in[3] = bus.preset_min_tens;
    assign borrow[0]    = 1'b1;

    // Units digits wrap/clamp at 9, tens digits at 5.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = (gi % 2 == 0) ? 4'd9 : 4'd5;
            assign preset_clean[gi] = (preset_in[gi] > LIMIT) ? LIMIT : preset_in[gi];
            assign borrow[gi+1]     = borrow[gi] && (digit_reg[gi] == 4'd0);
            assign digit_dec[gi]    = !borrow[gi]              ? digit_reg[gi] :
                                      (digit_reg[gi] == 4'd0)  ? LIMIT :
                                                                 digit_reg[gi] - 4'd1;
        end
    endgenerate

    assign count_zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) &&
                        (digit_reg[2] == 4'd0) && (digit_reg[3] == 4'd0);
    assign count_one  = (digit_reg[0] == 4'd1) && (digit_reg[1] == 4'd0) &&
                        (digit_reg[2] == 4'd0) && (digit_reg[3] == 4'd0);

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            done_reg      <= 1'b0;
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= 4'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                preset_reg[i] <= 4'd0;
`endif
            end
        end else begin
            state_reg     <= state_next;
            done_reg      <= done_next;
            alarm_reg     <= alarm_next;
            alarm_cnt_reg <= alarm_cnt_next;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= digit_next[i];
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                preset_reg[i] <= preset_next[i];
`endif
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        digit_next     = digit_reg;
        done_next      = done_reg;
        alarm_next     = alarm_reg;
        alarm_cnt_next = alarm_cnt_reg;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        preset_next    = preset_reg;
`endif
        if (bus.load) begin
            digit_next     = preset_clean;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_next    = preset_clean;
`endif
            state_next     = IDLE;
            done_next      = 1'b0;
            alarm_next     = 1'b0;
            alarm_cnt_next = '0;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_next = 1'b0;
`endif
            if (alarm_reg) begin
                if (alarm_cnt_reg == '0)
                    alarm_next = 1'b0;
                else
                    alarm_cnt_next = alarm_cnt_reg - ACW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (bus.enable && !count_zero)
                        state_next = RUN;
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_next = PAUSE;
                    end else if (count_one) begin
                        // Expiry restarts the alarm even if a previous one is still running.
                        done_next = 1'b1;
                        if (ALARM_CYCLES > 0) begin
                            alarm_next     = 1'b1;
                            alarm_cnt_next = ACW'(ALARM_CYCLES - 1);
                        end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        digit_next = preset_reg;
`else
                        digit_next = digit_dec;
                        state_next = DONE;
`endif
                    end else begin
                        digit_next = digit_dec;
                    end
                end
                PAUSE: begin
                    if (bus.enable)
                        state_next = RUN;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.sec_unit = digit_reg[0];
        bus.sec_tens = digit_reg[1];
        bus.min_unit = digit_reg[2];
        bus.min_tens = digit_reg[3];
        bus.state    = state_reg;
        bus.running  = (state_reg == RUN);
        bus.done     = done_reg;
        bus.alarm    = alarm_reg;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (ALARM_CYCLES = 10).
// Digits are compared packed as 16'hMMSS.
module tb_countdown_timer;

    logic clk_1hz = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    countdown_timer_if bus ();

    countdown_timer #(.ALARM_CYCLES(10)) dut (
        .clk_1hz (clk_1hz),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_unit, bus.sec_tens, bus.sec_unit};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
        $display("t=%0t load=%0b en=%0b digits=%04h state=%0d run=%0b done=%0b alarm=%0b",
                 $time, bus.load, bus.enable, digits(), bus.state, bus.running, bus.done, bus.alarm);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_preset(input logic [3:0] mt, input logic [3:0] mu,
                               input logic [3:0] st, input logic [3:0] su);
        bus.preset_min_tens = mt;
        bus.preset_min_unit = mu;
        bus.preset_sec_tens = st;
        bus.preset_sec_unit = su;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.load = 1'b0;
        bus.enable = 1'b0;
        bus.preset_min_tens = 4'd0;
        bus.preset_min_unit = 4'd0;
        bus.preset_sec_tens = 4'd0;
        bus.preset_sec_unit = 4'd0;
        #1 reset = 1'b1;
        #2;
        check("rst_digits", digits(), 16'h0000);
        check("rst_state", bus.state, 2'd0);
        check("rst_running", bus.running, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_alarm", bus.alarm, 1'b0);
        tick();
        reset = 1'b0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // 00:03 to expiry, then the alarm window
        load_preset(4'd0, 4'd0, 4'd0, 4'd3);
        check("ld3_digits", digits(), 16'h0003);
        check("ld3_state", bus.state, 2'd0);
        bus.enable = 1'b1;
        tick();
        check("e1_state", bus.state, 2'd1);
        check("e1_running", bus.running, 1'b1);
        check("e1_digits", digits(), 16'h0003);
        tick();
        check("e2_digits", digits(), 16'h0002);
        tick();
        check("e3_digits", digits(), 16'h0001);
        check("e3_done", bus.done, 1'b0);
        tick();
        check("e4_digits", digits(), 16'h0000);
        check("e4_state", bus.state, 2'd3);
        check("e4_done", bus.done, 1'b1);
        check("e4_alarm", bus.alarm, 1'b1);
        check("e4_running", bus.running, 1'b0);
        ticks(9);
        check("alarm_last_cycle", bus.alarm, 1'b1);
        check("done_hold_digits", digits(), 16'h0000);
        check("done_hold_state", bus.state, 2'd3);
        tick();
        check("alarm_dropped", bus.alarm, 1'b0);
        check("done_still_high", bus.done, 1'b1);
`endif

        // borrow chains
        bus.enable = 1'b1;
        load_preset(4'd1, 4'd0, 4'd0, 4'd0);
        check("ld1000_state", bus.state, 2'd0);
        check("ld1000_done", bus.done, 1'b0);
        ticks(2);
        check("borrow_1000", digits(), 16'h0959);
        load_preset(4'd0, 4'd1, 4'd0, 4'd0);
        ticks(2);
        check("borrow_0100", digits(), 16'h0059);
        load_preset(4'd0, 4'd0, 4'd1, 4'd0);
        ticks(2);
        check("borrow_0010", digits(), 16'h0009);

        // pause and resume
        load_preset(4'd0, 4'd0, 4'd0, 4'd5);
        ticks(3);
        check("pre_pause_digits", digits(), 16'h0003);
        bus.enable = 1'b0;
        tick();
        check("pause_state", bus.state, 2'd2);
        check("pause_running", bus.running, 1'b0);
        ticks(3);
        check("pause_hold_digits", digits(), 16'h0003);
        check("pause_hold_state", bus.state, 2'd2);
        bus.enable = 1'b1;
        tick();
        check("resume_state", bus.state, 2'd1);
        check("resume_no_dec", digits(), 16'h0003);
        tick();
        check("resume_dec", digits(), 16'h0002);

        // clamping and zero preset
        load_preset(4'd9, 4'hF, 4'd7, 4'hC);
        check("clamp_digits", digits(), 16'h5959);
        check("clamp_state", bus.state, 2'd0);
        load_preset(4'd0, 4'd0, 4'd0, 4'd0);
        ticks(2);
        check("zero_state", bus.state, 2'd0);
        check("zero_done", bus.done, 1'b0);
        check("zero_alarm", bus.alarm, 1'b0);

        // load mid-run
        load_preset(4'd0, 4'd0, 4'd0, 4'd9);
        ticks(3);
        check("midrun_digits", digits(), 16'h0007);
        load_preset(4'd0, 4'd0, 4'd0, 4'd2);
        check("midrun_ld_state", bus.state, 2'd0);
        check("midrun_ld_digits", digits(), 16'h0002);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // async reset while DONE with alarm high
        ticks(3);
        check("pre_rst_state", bus.state, 2'd3);
        check("pre_rst_alarm", bus.alarm, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_digits", digits(), 16'h0000);
        check("async_state", bus.state, 2'd0);
        check("async_done", bus.done, 1'b0);
        check("async_alarm", bus.alarm, 1'b0);
        check("async_running", bus.running, 1'b0);
        tick();
        reset = 1'b0;
        ticks(2);
        check("post_rst_idle", bus.state, 2'd0);
`else
        // auto reload: 00:02, 00:01, 00:02 (done pulse), 00:01, 00:02 ...
        tick();
        check("ar_e1", digits(), 16'h0002);
        check("ar_e1_state", bus.state, 2'd1);
        tick();
        check("ar_e2", digits(), 16'h0001);
        tick();
        check("ar_e3_digits", digits(), 16'h0002);
        check("ar_e3_state", bus.state, 2'd1);
        check("ar_e3_done", bus.done, 1'b1);
        check("ar_e3_alarm", bus.alarm, 1'b1);
        tick();
        check("ar_e4_digits", digits(), 16'h0001);
        check("ar_e4_done", bus.done, 1'b0);
        tick();
        check("ar_e5_digits", digits(), 16'h0002);
        check("ar_e5_done", bus.done, 1'b1);
        check("ar_e5_state", bus.state, 2'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
